uart_tx: RTL and testbench

Byte-wide UART transmitter producing 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at `CLKS_PER_BIT` clocks per bit. It is the transmit-side counterpart of the existing `uart` receiver. It sits between the core or debug logic and the board TX pin. A small input FIFO with a valid/ready handshake lets the producer queue several bytes, and frames are sent back-to-back with no idle gap.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 56 +++++
 rtl/uart_tx.sv | 125 ++++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor for 100 MHz / 115200, frame shape,
// and the transmitter state type.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_115200 = 868;
    localparam int unsigned UART_DATA_BITS      = 8;
    localparam int unsigned UART_STOP_BITS      = 1;

    typedef enum logic [1:0] {
        IDLE,
        TX_START_BIT,
        TX_DATA_BITS,
        TX_STOP_BIT
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; show-ahead read port so the head
// byte can be loaded into the shift register on the same edge it is popped.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [UART_DATA_BITS-1:0] wr_data,
    input  logic                      rd_en,
    output logic [UART_DATA_BITS-1:0] rd_data,
    output logic                      full,
    output logic                      empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W:0]            count;
    logic                      push;
    logic                      pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with an input FIFO; frames queued in the FIFO are sent
// back-to-back with no idle gap between stop bit and next start bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    output logic       tx_ready,
    output logic       tx_serial,
    output logic       tx_busy
);

    localparam int unsigned           CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]            IDX_LAST = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t            state;
    logic [CNT_W-1:0]          clk_cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] fifo_head;
    logic                      fifo_rd;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      bit_done;

    assign bit_done = (clk_cnt == CNT_LAST);
    assign tx_ready = !fifo_full;

    always_comb begin
        fifo_rd = !fifo_empty && ((state == IDLE) || ((state == TX_STOP_BIT) && bit_done));
    end

    uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (tx_byte_valid),
        .wr_data(tx_byte),
        .rd_en  (fifo_rd),
        .rd_data(fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    clk_cnt   <= '0;
                    bit_idx   <= '0;
                    if (!fifo_empty) begin
                        shift     <= fifo_head;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= TX_START_BIT;
                    end
                end
                TX_START_BIT: begin
                    if (bit_done) begin
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        tx_serial <= shift[0];
                        state     <= TX_DATA_BITS;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                // The line is driven from shift[1] as the register shifts, so the
                // next bit appears on the same edge the current one retires.
                TX_DATA_BITS: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (bit_idx == IDX_LAST) begin
                            tx_serial <= 1'b1;
                            state     <= TX_STOP_BIT;
                        end else begin
                            shift     <= {1'b0, shift[UART_DATA_BITS-1:1]};
                            tx_serial <= shift[1];
                            bit_idx   <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                TX_STOP_BIT: begin
                    if (bit_done) begin
                        clk_cnt <= '0;
                        if (!fifo_empty) begin
                            shift     <= fifo_head;
                            tx_serial <= 1'b0;
                            state     <= TX_START_BIT;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_serial <= 1'b1;
                    tx_busy   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed/randomized bench for uart_tx: expected line levels are built from
// queued bytes as 10-bit frames {stop, data, start} held CLKS_PER_BIT cycles each.
module tb_uart_tx;

    localparam int unsigned C     = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_byte = '0;
    logic       tx_byte_valid = 1'b0;
    logic       tx_ready;
    logic       tx_serial;
    logic       tx_busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    logic [7:0]  exp_q[$];

    uart_tx #(
        .CLKS_PER_BIT(C),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_byte      (tx_byte),
        .tx_byte_valid(tx_byte_valid),
        .tx_ready     (tx_ready),
        .tx_serial    (tx_serial),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] b, output int unsigned acc_cyc);
        acc_cyc = 0;
        tx_byte = b;
        tx_byte_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (tx_ready) begin
                @(posedge clk);
                exp_q.push_back(b);
                @(negedge clk);
                acc_cyc = cyc;
                tx_byte_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("push_timeout", tx_ready, 1);
        tx_byte_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int unsigned exp_lat);
        int unsigned n = 0;
        while (tx_serial !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n, exp_lat);
    endtask

    // Starts on the first negedge of a start bit; checks every cycle of
    // 'frames' consecutive frames, then the idle line that must follow.
    task automatic run_line(input string tag, input int unsigned frames);
        logic [7:0] b;
        logic [9:0] fr;
        for (int unsigned f = 0; f < frames; f++) begin
            b  = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            fr = {1'b1, b, 1'b0};
            for (int unsigned k = 0; k < 10; k++) begin
                for (int unsigned c = 0; c < C; c++) begin
                    chk({tag, "_serial"}, tx_serial, fr[k]);
                    chk({tag, "_busy"}, tx_busy, 1);
                    @(negedge clk);
                end
            end
        end
        chk({tag, "_idle_serial"}, tx_serial, 1);
        chk({tag, "_idle_busy"}, tx_busy, 0);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    int unsigned acc[6];
    int unsigned a;
    logic [7:0]  rb[6];
    int unsigned k;

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_serial", tx_serial, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", tx_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_serial", tx_serial, 1);

        // Single byte 0x55
        push(8'h55, a);
        wait_start("t1_latency", 1);
        run_line("t1", 1);

        // Two bytes on consecutive cycles, back-to-back frames
        push(8'hA5, a);
        push(8'h3C, a);
        wait_start("t2_latency", 0);
        run_line("t2", 2);

        // Six random bytes with valid held: FIFO fills, sixth waits for a pop
        for (int i = 0; i < 6; i++) rb[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(rb[i], acc[i]);
                    if (i >= 1 && i <= 4) chk("t3_accept_cycle", acc[i] - acc[0], i);
                    if (i == 4) chk("t3_ready_full", tx_ready, 0);
                end
                chk("t3_sixth_accept", acc[5] - acc[0], 10 * C + 2);
            end
            begin
                wait_start("t3_latency", 2);
                run_line("t3", 6);
            end
        join

        // Reset during data bit 3 of 0xF0 with two bytes queued
        push(8'hF0, a);
        push(8'($urandom), a);
        push(8'($urandom), a);
        wait_start("t4_latency", 0);
        repeat (4 * C + 3) @(negedge clk);
        chk("t4_bit3", tx_serial, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_serial", tx_serial, 1);
        chk("t4_rst_busy", tx_busy, 0);
        chk("t4_rst_ready", tx_ready, 1);
        rst_n = 1'b1;
        exp_q.delete();
        for (int unsigned i = 0; i < 25 * C; i++) begin
            @(negedge clk);
            chk("t4_quiet_serial", tx_serial, 1);
            chk("t4_quiet_busy", tx_busy, 0);
        end
        push(8'($urandom), a);
        wait_start("t4_after_latency", 1);
        run_line("t4", 1);

        // Push coinciding with the pop at stop-bit end, one byte queued
        push(8'($urandom), a);
        push(8'($urandom), a);
        wait_start("t5_latency", 0);
        fork
            run_line("t5", 3);
            begin
                repeat (10 * C - 1) @(negedge clk);
                push(8'($urandom), a);
                chk("t5_ready", tx_ready, 1);
            end
        join

        // Random bursts with random idle gaps
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            chk("t6_gap_serial", tx_serial, 1);
            k = $urandom_range(1, 3);
            for (int unsigned j = 0; j < k; j++) push(8'($urandom), a);
            wait_start("t6_latency", (k == 1) ? 1 : 0);
            run_line("t6", k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
